decoder_scan_n: RTL
===================

Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Two modes:
  - Direct: decodes the `sel` input.
  - Scan: an internal position counter steps through every output, holding each one for DWELL cycles.
- Drives row/digit-select lines for multiplexed displays and keypad scanning. Replaces the fixed combinational 3-to-8 decoder.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL, 4, cycles each output stays active in scan mode; legal range is 1 or more.
- ACTIVE_LOW, 0, when set to 1 every bit of y is inverted (inactive = 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enable; when low, outputs go inactive and scan state is frozen.
- mode  input  1  0 = direct, 1 = scan.
- sel  input  N  address decoded in direct mode.
- y  output  2^N  registered one-hot (or one-cold) select lines.
- idx  output  N  registered index currently driven on y.
- valid  output  1  high when y carries an active select.
- wrap  output  1  one-cycle pulse when the scan position wraps from 2^N-1 to 0.

Behaviour:
- Reset state (applies immediately on the rst_n fall, no clock needed):
  - y = all-inactive (0s, or 1s when ACTIVE_LOW).
  - idx = 0, valid = 0, wrap = 0.
  - Internal pos = 0, dcnt = 0, last_scan = 0.
- All outputs are registered. Latency from input to y is 1 clock.
- Internal state:
  - pos: N-bit scan position.
  - dcnt: dwell counter, width max(1, clog2(DWELL)).
  - last_scan: set to 1 when the previous enabled cycle was in scan mode.
- en = 0 at an edge:
  - y inactive, valid = 0, wrap = 0.
  - pos, dcnt and last_scan hold; idx holds.
- en = 1, mode = 0 (direct) at an edge:
  - y = onehot(sel), idx = sel, valid = 1, wrap = 0, last_scan = 0.
  - pos and dcnt hold.
- en = 1, mode = 1, last_scan = 0 (scan entry):
  - pos = 0, dcnt = 0, y = onehot(0), idx = 0, valid = 1, wrap = 0, last_scan = 1.
- en = 1, mode = 1, last_scan = 1, dcnt < DWELL-1:
  - dcnt increments; y = onehot(pos), idx = pos, valid = 1, wrap = 0.
- en = 1, mode = 1, last_scan = 1, dcnt = DWELL-1:
  - dcnt = 0, pos = pos+1 (mod 2^N), y = onehot(pos+1), idx = pos+1, valid = 1.
  - wrap = 1 only if the old pos was 2^N-1.
- Each index is therefore held for exactly DWELL consecutive enabled cycles. With DWELL = 1 the position advances every cycle.
- Pause and resume:
  - Dropping en mid-scan preserves pos and dcnt.
  - Re-enabling in scan mode resumes with no restart, because last_scan is still 1.
  - Switching to direct mode and back to scan restarts the scan at position 0.
- ACTIVE_LOW inversion is applied at the output register only. idx, valid and wrap are unaffected.
- Exactly one bit of y is active whenever valid = 1; none is active when valid = 0.

Decomposition:
- Shared package decoder_pkg:
  - Constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - Dwell counter width function (max(1, clog2(DWELL))).
- Sub-module decoder_n_core:
  - Purely combinational N-to-2^N one-hot decode with parameter N.
  - Instantiated once; its input is muxed between sel and the next scan position.
- All registers and mode control stay in decoder_scan_n.

Test Plan (N=3, DWELL=4, ACTIVE_LOW=0 unless noted):
1. Reset: hold rst_n = 0, then release -> y = 8'h00, idx = 0, valid = 0, wrap = 0. Assert rst_n = 0 mid-scan -> y = 8'h00 with no clock edge needed.
2. Direct sweep: en = 1, mode = 0, sel = 0..7 on consecutive cycles -> one cycle later y = 8'h01, 02, 04, ..., 80, idx equals sel, valid = 1. For sel = 5, y = 8'h20.
3. Enable off: en = 0 after sel = 5 -> next edge y = 8'h00 and valid = 0; idx stays 5.
4. Scan cycle: en = 1, mode = 1 from direct:
   - y = 8'h01 for 4 cycles, then 8'h02 for 4 cycles, ..., 8'h80 for 4 cycles.
   - After 32 cycles y returns to 8'h01 with wrap = 1 for exactly that one cycle.
5. Pause and resume: drop en for 3 cycles at pos = 2, dcnt = 1.
   - While paused, y = 8'h00.
   - After re-enable, y = 8'h04 for 2 cycles, then 8'h08.
   - A mode 1 -> 0 -> 1 round trip restarts the scan at 8'h01.
6. ACTIVE_LOW = 1 and DWELL = 1 instance:
   - After reset, y = 8'hFF.
   - Direct sel = 3 -> y = 8'hF7.
   - Scan -> y changes every cycle (FE, FD, FB, ...) and wrap pulses every 8 cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared mode encodings and dwell-counter sizing for the scanning decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Dwell counter must be at least one bit even when DWELL is 1.
    function automatic int dcnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/decoder_n_core.sv
// Combinational N-to-2^N one-hot decode; zero latency, no flow control.
module decoder_n_core #(
    parameter int N = 3
) (
    input  logic [N-1:0]    addr,
    output logic [2**N-1:0] onehot
);

    localparam logic [2**N-1:0] ONE = {{(2**N-1){1'b0}}, 1'b1};

    assign onehot = ONE << addr;

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct and dwell-timed scan modes.
// One clock from inputs to y; no backpressure, en low freezes scan state.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int              W        = 2**N;
    localparam int              DW       = dcnt_width(DWELL);
    localparam logic [DW-1:0]   DLAST    = DW'(DWELL - 1);
    localparam logic [W-1:0]    INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    logic [N-1:0]  pos;
    logic [DW-1:0] dcnt;
    logic          last_scan;

    logic          scan_entry;
    logic          advance;
    logic [N-1:0]  pos_nxt;
    logic [N-1:0]  dec_addr;
    logic [W-1:0]  dec_onehot;

    assign scan_entry = (mode == MODE_SCAN) && !last_scan;
    assign advance    = (mode == MODE_SCAN) && last_scan && (dcnt == DLAST);

    always_comb begin
        pos_nxt = pos;
        if (scan_entry) begin
            pos_nxt = '0;
        end else if (advance) begin
            pos_nxt = pos + N'(1);
        end
    end

    // A single decoder serves both modes; the scan path decodes the position
    // that will be current after this edge so y and idx stay aligned.
    assign dec_addr = (mode == MODE_SCAN) ? pos_nxt : sel;

    decoder_n_core #(.N(N)) u_core (
        .addr   (dec_addr),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= INACTIVE;
            idx       <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            pos       <= '0;
            dcnt      <= '0;
            last_scan <= 1'b0;
        end else if (!en) begin
            y     <= INACTIVE;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (mode == MODE_DIRECT) begin
            y         <= dec_onehot ^ INACTIVE;
            idx       <= sel;
            valid     <= 1'b1;
            wrap      <= 1'b0;
            last_scan <= 1'b0;
        end else begin
            y         <= dec_onehot ^ INACTIVE;
            idx       <= pos_nxt;
            valid     <= 1'b1;
            wrap      <= advance && (pos == {N{1'b1}});
            pos       <= pos_nxt;
            dcnt      <= (scan_entry || advance) ? '0 : dcnt + DW'(1);
            last_scan <= 1'b1;
        end
    end

endmodule
